cp_top: RTL and testbench

APB-programmable AES-128 encryption coprocessor. Software writes a 128-bit key and a 128-bit plaintext block into memory-mapped registers, then starts the core. The core computes one round per cycle and stores the ciphertext in read-only registers. On completion it raises a maskable, level interrupt `oInt`.

---
 rtl/cp_top.sv | 207 ++++++++++++++++++++
 tb/tb_cp_top.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp_top.sv
// cp_top: APB-programmable AES-128 encryption coprocessor, one round per clock.
// Optional macro CP_BUSY_LOCK_EN drops KEY/TEXT/SIZE writes while the core is busy.
module cp_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x14, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(x3, x3);
    x12  = gmul(x12, x12);
    x14  = gmul(x12, x2);
    x15  = gmul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
    return gmul(x240, x14);
  endfunction

  logic [7:0] v;
  always_comb begin
    v = ginv(a);
    s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  end
endmodule

module cp_top #(
  parameter int NROUND = 10
) (
  input  logic        iClk,
  input  logic        iRsn,
  input  logic        iPsel,
  input  logic        iPenable,
  input  logic        iPwrite,
  input  logic [15:0] iPaddr,
  input  logic [31:0] iPwdata,
  output logic [31:0] oPrdata,
  output logic        oInt
);
  typedef enum logic {IDLE, ROUND} state_t;
  state_t state, state_nxt;

  logic [15:0]  size_r;
  logic [127:0] key_r, text_r, out_r, st_r, rk_r;
  logic [3:0]   round_r;
  logic         inten_r, intpend_r, intgen_r;
  logic         wr, busy, start, last, lock;
  logic [127:0] sb, sr, mc, nk, nxt_st;
  logic [31:0]  ks, temp;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = c;
    return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign wr    = iPsel & iPenable & iPwrite;
  assign busy  = (state == ROUND);
  assign start = wr && (iPaddr == 16'h0000) && iPwdata[0] && !busy && (size_r != 16'h0000);
  assign last  = busy && (round_r == 4'(NROUND));
  assign oInt  = intpend_r & inten_r & intgen_r;
`ifdef CP_BUSY_LOCK_EN
  assign lock  = busy;
`else
  assign lock  = 1'b0;
`endif

  for (genvar n = 0; n < 16; n++) begin : g_sb
    cp_sbox u_sb (.a(st_r[8*n +: 8]), .s(sb[8*n +: 8]));
  end
  for (genvar n = 0; n < 4; n++) begin : g_ks
    cp_sbox u_ks (.a(rk_r[96+8*n +: 8]), .s(ks[8*n +: 8]));
  end

  // Round datapath: ShiftRows, MixColumns and on-the-fly key expansion
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
    for (int c = 0; c < 4; c++) mc[32*c +: 32] = mixcol(sr[32*c +: 32]);
    temp = {ks[7:0], ks[31:24], ks[23:16], ks[15:8] ^ rcon(round_r)};
    nk[31:0]   = rk_r[31:0]   ^ temp;
    nk[63:32]  = rk_r[63:32]  ^ nk[31:0];
    nk[95:64]  = rk_r[95:64]  ^ nk[63:32];
    nk[127:96] = rk_r[127:96] ^ nk[95:64];
    nxt_st = (last ? sr : mc) ^ nk;
  end

  always_ff @(posedge iClk) begin
    if (iRsn) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROUND;
      ROUND:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRsn) begin
      size_r <= '0; key_r <= '0; text_r <= '0; out_r <= '0;
      st_r <= '0; rk_r <= '0; round_r <= '0;
      inten_r <= 1'b0; intpend_r <= 1'b0; intgen_r <= 1'b0;
    end else begin
      if (wr) begin
        case (iPaddr)
          16'h0004: if (!lock) size_r <= iPwdata[15:0];
          16'h2000: if (!lock) key_r[31:0]    <= iPwdata;
          16'h2004: if (!lock) key_r[63:32]   <= iPwdata;
          16'h2008: if (!lock) key_r[95:64]   <= iPwdata;
          16'h200C: if (!lock) key_r[127:96]  <= iPwdata;
          16'h4000: if (!lock) text_r[31:0]   <= iPwdata;
          16'h4004: if (!lock) text_r[63:32]  <= iPwdata;
          16'h4008: if (!lock) text_r[95:64]  <= iPwdata;
          16'h400C: if (!lock) text_r[127:96] <= iPwdata;
          16'hA000: inten_r  <= iPwdata[0];
          16'hA008: intgen_r <= iPwdata[0];
          default: ;
        endcase
      end
      if (start) begin
        st_r    <= text_r ^ key_r;
        rk_r    <= key_r;
        round_r <= 4'd1;
      end else if (busy) begin
        st_r    <= nxt_st;
        rk_r    <= nk;
        round_r <= round_r + 4'd1;
        if (last) out_r <= nxt_st;
      end
      // Completion outranks a software clear landing on the same edge
      if (last) intpend_r <= 1'b1;
      else if (wr && (iPaddr == 16'hA004) && iPwdata[0]) intpend_r <= 1'b0;
    end
  end

  always_comb begin
    oPrdata = '0;
    if (iPsel && !iPwrite) begin
      case (iPaddr)
        16'h0000: oPrdata = {31'b0, busy};
        16'h0004: oPrdata = {16'b0, size_r};
        16'h2000: oPrdata = key_r[31:0];
        16'h2004: oPrdata = key_r[63:32];
        16'h2008: oPrdata = key_r[95:64];
        16'h200C: oPrdata = key_r[127:96];
        16'h4000: oPrdata = text_r[31:0];
        16'h4004: oPrdata = text_r[63:32];
        16'h4008: oPrdata = text_r[95:64];
        16'h400C: oPrdata = text_r[127:96];
        16'h6000: oPrdata = out_r[31:0];
        16'h6004: oPrdata = out_r[63:32];
        16'h6008: oPrdata = out_r[95:64];
        16'h600C: oPrdata = out_r[127:96];
        16'hA000: oPrdata = {31'b0, inten_r};
        16'hA004: oPrdata = {31'b0, intpend_r};
        16'hA008: oPrdata = {31'b0, intgen_r};
        default:  oPrdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cp_top.sv
// tb_cp_top: directed bench for the AES-128 coprocessor using FIPS-197 and all-zero vectors.
module tb_cp_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] V1_KEY = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
  localparam logic [127:0] V1_TXT = {32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100};
  localparam logic [127:0] V1_CT  = {32'h5AC5B470, 32'h80B7CDD8, 32'h30047B6A, 32'hD8E0C469};
  localparam logic [127:0] V0_CT  = {32'h2E2B34CA, 32'h59FA4C88, 32'h3B2C8AEF, 32'hD44BE966};

  cp_top dut (
    .iClk(clk), .iRsn(rst), .iPsel(psel), .iPenable(penable), .iPwrite(pwrite),
    .iPaddr(paddr), .iPwdata(pwdata), .oPrdata(prdata), .oInt(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] t);
    for (int i = 0; i < 4; i++) apb_write(16'h2000 + 16'(4*i), k[32*i +: 32]);
    for (int i = 0; i < 4; i++) apb_write(16'h4000 + 16'(4*i), t[32*i +: 32]);
  endtask

  task automatic check_out(input string tag, input logic [127:0] exp);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      apb_read(16'h6000 + 16'(4*i), d);
      check($sformatf("%s_out%0d", tag, i), d, exp[32*i +: 32]);
    end
  endtask

  // Counts edges after the start write until oInt rises, bounded
  task automatic wait_int(input int n0, output int n);
    n = n0;
    while (irq !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_int", {31'b0, irq}, 32'h0);
    check("rst_prdata_idle", prdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    vt.push_back('{1'b0, 16'h0000, 32'h0});
    vt.push_back('{1'b0, 16'h0004, 32'h0});
    vt.push_back('{1'b0, 16'h2000, 32'h0});
    vt.push_back('{1'b0, 16'h400C, 32'h0});
    vt.push_back('{1'b0, 16'h6000, 32'h0});
    vt.push_back('{1'b0, 16'hA000, 32'h0});
    vt.push_back('{1'b0, 16'hA004, 32'h0});
    vt.push_back('{1'b0, 16'hA008, 32'h0});
    vt.push_back('{1'b0, 16'h8000, 32'h0});
    vt.push_back('{1'b1, 16'h0004, 32'h1234BEEF});
    vt.push_back('{1'b0, 16'h0004, 32'h0000BEEF});
    vt.push_back('{1'b1, 16'h2004, 32'hCAFEF00D});
    vt.push_back('{1'b0, 16'h2004, 32'hCAFEF00D});
    vt.push_back('{1'b1, 16'h200C, 32'h12345678});
    vt.push_back('{1'b0, 16'h2008, 32'h0});
    vt.push_back('{1'b1, 16'h6000, 32'hFFFFFFFF});
    vt.push_back('{1'b0, 16'h6000, 32'h0});
    vt.push_back('{1'b1, 16'h8000, 32'hFFFFFFFF});
    vt.push_back('{1'b0, 16'h8000, 32'h0});
    vt.push_back('{1'b1, 16'hA000, 32'h00000003});
    vt.push_back('{1'b0, 16'hA000, 32'h1});
    vt.push_back('{1'b1, 16'hA004, 32'h0});
    vt.push_back('{1'b0, 16'hA004, 32'h0});

    foreach (vt[i]) begin
      if (vt[i].wr) apb_write(vt[i].addr, vt[i].data);
      else begin
        apb_read(vt[i].addr, d);
        check($sformatf("vec%0d_%04h", i, vt[i].addr), d, vt[i].data);
      end
    end

    // FIPS-197 vector with interrupt enabled, latency measured from the start edge
    load(V1_KEY, V1_TXT);
    apb_write(16'hA000, 32'h1);
    apb_write(16'hA008, 32'h1);
    apb_write(16'h0004, 32'd16);
    apb_write(16'h0000, 32'h1);
    wait_int(0, n);
    check("v1_latency", 32'(n), 32'd10);
    check_out("v1", V1_CT);
    apb_read(16'h0000, d);
    check("v1_busy_done", d, 32'h0);

    // Interrupt clear
    apb_read(16'hA004, d);
    check("pend_set", d, 32'h1);
    apb_write(16'hA004, 32'h1);
    check("int_cleared", {31'b0, irq}, 32'h0);
    apb_read(16'hA004, d);
    check("pend_clr", d, 32'h0);

    // All-zero key and text, back-to-back without reset
    load('0, '0);
    apb_write(16'h0000, 32'h1);
    wait_int(0, n);
    check("v0_latency", 32'(n), 32'd10);
    check_out("v0", V0_CT);
    apb_write(16'hA004, 32'h1);

    // Masking by the global enable
    load(V1_KEY, V1_TXT);
    apb_write(16'hA008, 32'h0);
    apb_write(16'h0000, 32'h1);
    repeat (12) @(posedge clk);
    #1;
    check("mask_int_low", {31'b0, irq}, 32'h0);
    apb_read(16'hA004, d);
    check("mask_pend", d, 32'h1);
    apb_write(16'hA008, 32'h1);
    check("mask_int_high", {31'b0, irq}, 32'h1);
    apb_write(16'hA004, 32'h1);

    // Start ignored with SIZE == 0
    apb_write(16'h0004, 32'h0);
    apb_write(16'h0000, 32'h1);
    apb_read(16'h0000, d);
    check("size0_busy", d, 32'h0);
    apb_read(16'hA004, d);
    check("size0_pend", d, 32'h0);

    // Start while busy must not restart the core
    apb_write(16'h0004, 32'd16);
    apb_write(16'h0000, 32'h1);
    apb_write(16'h0000, 32'h1);
    apb_read(16'h0000, d);
    check("busy_flag", d, 32'h1);
    wait_int(4, n);
    check("restart_latency", 32'(n), 32'd10);
    check_out("rs", V1_CT);
    apb_write(16'hA004, 32'h1);

    // Reset in the middle of an operation
    apb_write(16'h0000, 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_int", {31'b0, irq}, 32'h0);
    check_out("mrst", '0);
    apb_read(16'h0000, d);
    check("mrst_busy", d, 32'h0);
    apb_read(16'h2000, d);
    check("mrst_key0", d, 32'h0);
    apb_read(16'h4000, d);
    check("mrst_text0", d, 32'h0);
    apb_read(16'h8000, d);
    check("mrst_unmapped", d, 32'h0);
    repeat (15) @(posedge clk);
    apb_read(16'hA004, d);
    check("mrst_no_pend", d, 32'h0);
    check("mrst_int_late", {31'b0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
